sdram_frame_arbiter: RTL and testbench
======================================

# sdram_frame_arbiter

Burst scheduler between the camera/display pixel FIFOs and the SDRAM controller. Watches the camera-side write FIFO fill level and the display-side read FIFO free space, and picks the next full-page burst (512 × 16-bit, write or read). Issues that burst as a one-cycle request to the controller and streams the burst data between the FIFOs and the controller. Keeps independent write and read frame address counters, resynchronised by vsync pulses.

## Interface
Parameters:
- BURST_LEN, 512, words per burst; must equal the controller's full-page length.
- FRAME_BURSTS, 600, bursts per frame (640×480 × 16 bit / 512).
- WR_URGENT, 1536, write FIFO level at or above which writes beat reads.
- LVL_W, 12, width of the FIFO level/space inputs.

Ports:
- clk  in  1  system clock, same domain as the SDRAM controller.
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk.
- cam_vsync  in  1  one-cycle pulse, already synchronised to clk; restarts the write frame.
- disp_vsync  in  1  one-cycle pulse, already synchronised to clk; restarts the read frame.
- rd_enable  in  1  display active; reads are scheduled only while high.
- wr_fifo_level  in  LVL_W  words available in the write FIFO (show-ahead).
- wr_fifo_data  in  16  head word of the write FIFO.
- wr_fifo_rd_en  out  1  pops the write FIFO.
- rd_fifo_space  in  LVL_W  free words in the read FIFO.
- rd_fifo_wr_en  out  1  pushes into the read FIFO.
- rd_fifo_data  out  16  data pushed into the read FIFO.
- ctl_ready  in  1  controller idle and able to accept a request.
- ctl_rw_en  out  1  request strobe to the controller.
- ctl_rw  out  1  request direction: 1 = read, 0 = write.
- ctl_f_addr  out  15  request address, {row[12:0], bank[1:0]}.
- ctl_f2s_data  out  16  write data to the controller.
- ctl_f2s_data_valid  in  1  controller consumes ctl_f2s_data at the next edge.
- ctl_s2f_data  in  16  read data from the controller.
- ctl_s2f_data_valid  in  1  read data valid.
- err_underrun  out  1  sticky error flag; see Configuration.
- err_stray  out  1  sticky error flag; see Configuration.

## Operation
- States:
  - IDLE: evaluates the arbitration conditions below.
  - REQ: request pending.
  - XFER_WR: write burst in progress.
  - XFER_RD: read burst in progress.
  - GAP: one-cycle gap.
- Eligibility, evaluated in IDLE:
  - wr_ok = wr_fifo_level ≥ BURST_LEN.
  - rd_ok = rd_enable && rd_fifo_space ≥ BURST_LEN.
- Arbitration, first match wins:
  - wr_ok && wr_fifo_level ≥ WR_URGENT → write.
  - rd_ok → read.
  - wr_ok → write.
  - Otherwise stay in IDLE.
- On a decision, ctl_rw and ctl_f_addr are registered and go to REQ. Both hold stable until the burst completes.
- Address: ctl_f_addr equals the 15-bit burst index of the chosen direction (wr_idx or rd_idx).
- REQ: ctl_rw_en = (state == REQ) && ctl_ready, combinational.
  - On the cycle ctl_rw_en is high, go to XFER_WR or XFER_RD.
  - While ctl_ready = 0, remain in REQ (controller busy refreshing).
- XFER_WR:
  - ctl_f2s_data = wr_fifo_data (combinational).
  - wr_fifo_rd_en = ctl_f2s_data_valid.
  - A 10-bit beat counter counts valid beats. At beat BURST_LEN go to GAP, and wr_idx advances.
- XFER_RD:
  - rd_fifo_wr_en = ctl_s2f_data_valid.
  - rd_fifo_data = ctl_s2f_data.
  - Beat counting is identical to XFER_WR; at BURST_LEN go to GAP, and rd_idx advances.
- GAP: returns to IDLE unconditionally. This guarantees the controller's ready has dropped before the next request.
- Index advance: idx+1, wrapping FRAME_BURSTS-1 → 0.
- Vsync handling:
  - cam_vsync sets wr_resync. disp_vsync sets rd_resync.
  - A resync flag zeroes its index in IDLE or GAP, never while a burst of that direction is in REQ or XFER.
  - When a flag is applied in GAP, it takes precedence over the increment from the burst just finished.
  - A vsync arriving while its flag is already set is absorbed.
- Reset mid-burst: all state returns to reset values immediately. The controller is reset by the same rst_n.

## Timing
- Reset values:
  - state IDLE; ctl_rw_en 0; ctl_rw 0; ctl_f_addr 0.
  - wr_fifo_rd_en 0; rd_fifo_wr_en 0; rd_fifo_data = ctl_s2f_data.
  - ctl_f2s_data = wr_fifo_data.
  - err flags 0; indices 0; resync flags 0; beat counter 0.
- Request latency: an eligible condition in IDLE → REQ next cycle → ctl_rw_en in that same cycle if ctl_ready = 1.
- Data path is zero-latency combinational in both directions. The write FIFO must be show-ahead.
- Minimum spacing between ctl_rw_en pulses: BURST_LEN + 3 cycles.

## Configuration
- Macro: FRAME_ARB_ERR_EN.
- Defined:
  - err_underrun is set when ctl_f2s_data_valid is high and wr_fifo_level = 0.
  - err_stray is set when ctl_s2f_data_valid is high outside XFER_RD, or ctl_f2s_data_valid is high outside XFER_WR.
  - Both flags are sticky until rst_n.
- Undefined: both outputs tied 0 and no checking logic is built.

## Test plan
- wr_fifo_level = 600, rd_enable = 0, ctl_ready = 1 → ctl_rw_en pulses one cycle with ctl_rw = 0, ctl_f_addr = 0; 512 f2s beats give exactly 512 wr_fifo_rd_en pulses; next write uses address 1.
- wr_fifo_level = 600, rd_fifo_space = 1024, rd_enable = 1 → read wins (ctl_rw = 1). Same stimulus with wr_fifo_level = 1600 → write wins.
- ctl_ready held 0 for 20 cycles in REQ → ctl_rw_en stays 0 throughout, then pulses once on the first cycle ctl_ready = 1.
- 600 consecutive write bursts → ctl_f_addr runs 0..599 and the 601st burst uses 0.
- cam_vsync during burst 5 of a write → that burst completes at address 5; the next write uses address 0.
- With FRAME_ARB_ERR_EN defined: inject ctl_s2f_data_valid in IDLE → err_stray = 1 next cycle and stays 1; assert rst_n low → err_stray = 0.

Source files
------------

// File: rtl/sdram_frame_arbiter.sv
// Full-page burst scheduler between the camera/display pixel FIFOs and the SDRAM controller.
// Optional sticky protocol-error flags are built only when FRAME_ARB_ERR_EN is defined.
module sdram_frame_arbiter #(
    parameter int unsigned BURST_LEN    = 512,
    parameter int unsigned FRAME_BURSTS = 600,
    parameter int unsigned WR_URGENT    = 1536,
    parameter int unsigned LVL_W        = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cam_vsync,
    input  logic             disp_vsync,
    input  logic             rd_enable,
    input  logic [LVL_W-1:0] wr_fifo_level,
    input  logic [15:0]      wr_fifo_data,
    output logic             wr_fifo_rd_en,
    input  logic [LVL_W-1:0] rd_fifo_space,
    output logic             rd_fifo_wr_en,
    output logic [15:0]      rd_fifo_data,
    input  logic             ctl_ready,
    output logic             ctl_rw_en,
    output logic             ctl_rw,
    output logic [14:0]      ctl_f_addr,
    output logic [15:0]      ctl_f2s_data,
    input  logic             ctl_f2s_data_valid,
    input  logic [15:0]      ctl_s2f_data,
    input  logic             ctl_s2f_data_valid,
    output logic             err_underrun,
    output logic             err_stray
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER_WR,
        XFER_RD,
        GAP
    } state_t;

    localparam logic [LVL_W-1:0] LVL_BURST  = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0] LVL_URGENT = LVL_W'(WR_URGENT);
    localparam logic [9:0]       LAST_BEAT  = 10'(BURST_LEN - 1);
    localparam logic [14:0]      LAST_IDX   = 15'(FRAME_BURSTS - 1);

    state_t      state_q, state_d;
    logic        rw_q, rw_d;
    logic [14:0] addr_q, addr_d;
    logic [9:0]  beat_q, beat_d;
    logic [14:0] wr_idx_q, wr_idx_d;
    logic [14:0] rd_idx_q, rd_idx_d;
    logic        wr_rs_q, wr_rs_d;
    logic        rd_rs_q, rd_rs_d;

    logic wr_ok, rd_ok, wr_urgent;

    assign wr_ok     = wr_fifo_level >= LVL_BURST;
    assign wr_urgent = wr_ok && (wr_fifo_level >= LVL_URGENT);
    assign rd_ok     = rd_enable && (rd_fifo_space >= LVL_BURST);

    assign ctl_rw       = rw_q;
    assign ctl_f_addr   = addr_q;
    assign ctl_f2s_data = wr_fifo_data;
    assign rd_fifo_data = ctl_s2f_data;

    function automatic logic [14:0] idx_next(input logic [14:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 15'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            beat_q   <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            wr_rs_q  <= 1'b0;
            rd_rs_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            wr_rs_q  <= wr_rs_d;
            rd_rs_q  <= rd_rs_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        beat_d        = beat_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        wr_rs_d       = wr_rs_q | cam_vsync;
        rd_rs_d       = rd_rs_q | disp_vsync;
        ctl_rw_en     = 1'b0;
        wr_fifo_rd_en = 1'b0;
        rd_fifo_wr_en = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A pending resync zeroes the index and also feeds the address chosen this cycle.
                if (wr_rs_q) begin
                    wr_idx_d = '0;
                    wr_rs_d  = cam_vsync;
                end
                if (rd_rs_q) begin
                    rd_idx_d = '0;
                    rd_rs_d  = disp_vsync;
                end
                if (wr_urgent) begin
                    rw_d    = 1'b0;
                    addr_d  = wr_rs_q ? '0 : wr_idx_q;
                    state_d = REQ;
                end else if (rd_ok) begin
                    rw_d    = 1'b1;
                    addr_d  = rd_rs_q ? '0 : rd_idx_q;
                    state_d = REQ;
                end else if (wr_ok) begin
                    rw_d    = 1'b0;
                    addr_d  = wr_rs_q ? '0 : wr_idx_q;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ctl_ready) begin
                    ctl_rw_en = 1'b1;
                    state_d   = rw_q ? XFER_RD : XFER_WR;
                end
            end
            XFER_WR: begin
                wr_fifo_rd_en = ctl_f2s_data_valid;
                if (ctl_f2s_data_valid) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = GAP;
                    end else begin
                        beat_d = beat_q + 10'd1;
                    end
                end
            end
            XFER_RD: begin
                rd_fifo_wr_en = ctl_s2f_data_valid;
                if (ctl_s2f_data_valid) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = GAP;
                    end else begin
                        beat_d = beat_q + 10'd1;
                    end
                end
            end
            GAP: begin
                // Index advance for the finished burst happens here so a resync can override it.
                state_d = IDLE;
                if (wr_rs_q) begin
                    wr_idx_d = '0;
                    wr_rs_d  = cam_vsync;
                end else if (!rw_q) begin
                    wr_idx_d = idx_next(wr_idx_q);
                end
                if (rd_rs_q) begin
                    rd_idx_d = '0;
                    rd_rs_d  = disp_vsync;
                end else if (rw_q) begin
                    rd_idx_d = idx_next(rd_idx_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FRAME_ARB_ERR_EN
    logic err_underrun_q, err_stray_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_underrun_q <= 1'b0;
            err_stray_q    <= 1'b0;
        end else begin
            if (ctl_f2s_data_valid && (wr_fifo_level == '0)) begin
                err_underrun_q <= 1'b1;
            end
            if ((ctl_s2f_data_valid && (state_q != XFER_RD)) ||
                (ctl_f2s_data_valid && (state_q != XFER_WR))) begin
                err_stray_q <= 1'b1;
            end
        end
    end

    assign err_underrun = err_underrun_q;
    assign err_stray    = err_stray_q;
`else
    assign err_underrun = 1'b0;
    assign err_stray    = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Directed bench for sdram_frame_arbiter: the bench plays the SDRAM controller and both FIFOs,
// predicts every request from the arbitration/index rules and checks the streaming path each cycle.
module tb_sdram_frame_arbiter;

    localparam int BL  = 512;
    localparam int FB  = 8;
    localparam int URG = 1536;
    localparam int LW  = 12;
`ifdef FRAME_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cam_vsync, disp_vsync, rd_enable;
    logic [LW-1:0] wr_fifo_level, rd_fifo_space;
    logic [15:0]   wr_fifo_data, rd_fifo_data, ctl_f2s_data, ctl_s2f_data;
    logic          wr_fifo_rd_en, rd_fifo_wr_en;
    logic          ctl_ready, ctl_rw_en, ctl_rw;
    logic [14:0]   ctl_f_addr;
    logic          ctl_f2s_data_valid, ctl_s2f_data_valid;
    logic          err_underrun, err_stray;

    always #5 clk = ~clk;

    sdram_frame_arbiter #(
        .BURST_LEN   (BL),
        .FRAME_BURSTS(FB),
        .WR_URGENT   (URG),
        .LVL_W       (LW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cam_vsync         (cam_vsync),
        .disp_vsync        (disp_vsync),
        .rd_enable         (rd_enable),
        .wr_fifo_level     (wr_fifo_level),
        .wr_fifo_data      (wr_fifo_data),
        .wr_fifo_rd_en     (wr_fifo_rd_en),
        .rd_fifo_space     (rd_fifo_space),
        .rd_fifo_wr_en     (rd_fifo_wr_en),
        .rd_fifo_data      (rd_fifo_data),
        .ctl_ready         (ctl_ready),
        .ctl_rw_en         (ctl_rw_en),
        .ctl_rw            (ctl_rw),
        .ctl_f_addr        (ctl_f_addr),
        .ctl_f2s_data      (ctl_f2s_data),
        .ctl_f2s_data_valid(ctl_f2s_data_valid),
        .ctl_s2f_data      (ctl_s2f_data),
        .ctl_s2f_data_valid(ctl_s2f_data_valid),
        .err_underrun      (err_underrun),
        .err_stray         (err_stray)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Frame model: next burst index per direction and pending resync requests.
    int m_wr_idx = 0, m_rd_idx = 0;
    bit m_wr_rs = 0, m_rd_rs = 0;

    function automatic bit pick_read(input int lvl, input int space, input bit en);
        bit w_ok = lvl >= BL;
        bit r_ok = en && (space >= BL);
        if (w_ok && lvl >= URG) return 1'b0;
        if (r_ok) return 1'b1;
        return 1'b0;
    endfunction

    // Burst bookkeeping shared with the compare process.
    bit          in_wr = 0, in_rd = 0;
    bit          req_rw;
    logic [14:0] req_addr;
    int          pops = 0, pushes = 0;
    int          cyc = 0, last_req = -100000;
    bit          got_rw;
    logic [14:0] got_addr;
    int          got_wait;

    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            chk("f2s_data_path", ctl_f2s_data, wr_fifo_data);
            chk("s2f_data_path", rd_fifo_data, ctl_s2f_data);
            chk("wr_fifo_pop", wr_fifo_rd_en, in_wr && ctl_f2s_data_valid);
            chk("rd_fifo_push", rd_fifo_wr_en, in_rd && ctl_s2f_data_valid);
            if (in_wr || in_rd) begin
                chk("hold_rw", ctl_rw, req_rw);
                chk("hold_addr", ctl_f_addr, req_addr);
            end
            if (ctl_rw_en) begin
                chk("req_while_busy", ctl_ready, 1'b1);
                chk("req_spacing_ok", (cyc - last_req) >= BL + 3, 1'b1);
                last_req = cyc;
            end
            if (wr_fifo_rd_en) pops++;
            if (rd_fifo_wr_en) pushes++;
        end else begin
            last_req = -100000;
        end
    end

    // Wait for a request, check it against the model, stream one burst, update the model.
    // vs_beat: pulse cam_vsync there (and again 10 beats later); rst_beat: reset mid-burst there.
    task automatic do_burst(input int vs_beat, input int rst_beat);
        bit   exp_rd;
        int   exp_addr, p0, q0, w;
        bit   found = 0;
        exp_rd   = pick_read(int'(wr_fifo_level), int'(rd_fifo_space), rd_enable);
        exp_addr = exp_rd ? m_rd_idx : m_wr_idx;
        for (w = 0; w < 60 && !found; w++) begin
            @(negedge clk);
            if (ctl_rw_en) found = 1;
        end
        got_wait = w - 1;
        chk("req_seen", found, 1'b1);
        if (!found) return;
        got_rw   = ctl_rw;
        got_addr = ctl_f_addr;
        chk("req_dir", ctl_rw, exp_rd);
        chk("req_addr", ctl_f_addr, exp_addr);
        req_rw   = exp_rd;
        req_addr = 15'(exp_addr);
        @(posedge clk); #1;
        ctl_ready = 1'b0;
        in_wr = !exp_rd;
        in_rd = exp_rd;
        p0 = pops;
        q0 = pushes;
        for (int b = 0; b < BL; b++) begin
            if (b % 128 == 64) begin
                ctl_f2s_data_valid = 1'b0;
                ctl_s2f_data_valid = 1'b0;
                @(posedge clk); #1;
            end
            wr_fifo_data       = 16'($urandom);
            ctl_s2f_data       = 16'($urandom);
            ctl_f2s_data_valid = !exp_rd;
            ctl_s2f_data_valid = exp_rd;
            cam_vsync          = (b == vs_beat) || (vs_beat >= 0 && b == vs_beat + 10);
            if (b == rst_beat) begin
                #2 rst_n = 1'b0;
                in_wr = 0;
                in_rd = 0;
                #1;
                chk("rst_req", ctl_rw_en, 1'b0);
                chk("rst_rw", ctl_rw, 1'b0);
                chk("rst_addr", ctl_f_addr, 15'd0);
                chk("rst_pop", wr_fifo_rd_en, 1'b0);
                ctl_f2s_data_valid = 1'b0;
                ctl_s2f_data_valid = 1'b0;
                cam_vsync = 1'b0;
                ctl_ready = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                m_wr_idx = 0; m_rd_idx = 0; m_wr_rs = 0; m_rd_rs = 0;
                return;
            end
            @(posedge clk); #1;
        end
        cam_vsync          = 1'b0;
        ctl_f2s_data_valid = 1'b0;
        ctl_s2f_data_valid = 1'b0;
        in_wr = 0;
        in_rd = 0;
        ctl_ready = 1'b1;
        chk(exp_rd ? "read_push_count" : "write_pop_count",
            exp_rd ? pushes - q0 : pops - p0, BL);
        if (vs_beat >= 0) m_wr_rs = 1;
        if (m_wr_rs) begin m_wr_idx = 0; m_wr_rs = 0; end
        else if (!exp_rd) m_wr_idx = (m_wr_idx + 1) % FB;
        if (m_rd_rs) begin m_rd_idx = 0; m_rd_rs = 0; end
        else if (exp_rd) m_rd_idx = (m_rd_idx + 1) % FB;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int highs;
        rst_n = 1'b0;
        cam_vsync = 0; disp_vsync = 0; rd_enable = 0;
        wr_fifo_level = '0; rd_fifo_space = '0;
        wr_fifo_data = 16'h1234; ctl_s2f_data = 16'hbeef;
        ctl_ready = 1'b1;
        ctl_f2s_data_valid = 0; ctl_s2f_data_valid = 0;
        repeat (3) @(posedge clk); #1;
        chk("reset_req", ctl_rw_en, 1'b0);
        chk("reset_rw", ctl_rw, 1'b0);
        chk("reset_addr", ctl_f_addr, 15'd0);
        chk("reset_pop", wr_fifo_rd_en, 1'b0);
        chk("reset_push", rd_fifo_wr_en, 1'b0);
        chk("reset_err_underrun", err_underrun, 1'b0);
        chk("reset_err_stray", err_stray, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Writes only: addresses 0,1,...,FB-1 then wrap to 0.
        wr_fifo_level = 12'd600;
        do_burst(-1, -1);
        chk("first_write_dir", got_rw, 1'b0);
        chk("first_write_addr", got_addr, 15'd0);
        do_burst(-1, -1);
        chk("second_write_addr", got_addr, 15'd1);
        for (int i = 2; i < FB; i++) do_burst(-1, -1);
        do_burst(-1, -1);
        chk("wrap_write_addr", got_addr, 15'd0);

        // Read beats a non-urgent write; an urgent write beats the read.
        rd_fifo_space = 12'd1024;
        rd_enable     = 1'b1;
        do_burst(-1, -1);
        chk("read_wins_dir", got_rw, 1'b1);
        chk("read_first_addr", got_addr, 15'd0);
        wr_fifo_level = 12'd1600;
        do_burst(-1, -1);
        chk("urgent_write_dir", got_rw, 1'b0);
        chk("urgent_write_addr", got_addr, 15'd1);

        // disp_vsync while idle restarts the read frame.
        wr_fifo_level = '0;
        rd_enable     = 1'b0;
        repeat (3) @(posedge clk); #1;
        disp_vsync = 1'b1;
        @(posedge clk); #1;
        disp_vsync = 1'b0;
        m_rd_idx = 0;
        repeat (3) @(posedge clk); #1;
        rd_enable = 1'b1;
        do_burst(-1, -1);
        chk("read_after_vsync_addr", got_addr, 15'd0);
        rd_enable = 1'b0;
        repeat (4) @(posedge clk); #1;

        // Controller busy: request held off for 20 cycles, then issued at once.
        ctl_ready     = 1'b0;
        wr_fifo_level = 12'd600;
        highs = 0;
        repeat (20) begin
            @(negedge clk);
            if (ctl_rw_en) highs++;
        end
        chk("busy_no_request", highs, 0);
        @(posedge clk); #1;
        ctl_ready = 1'b1;
        do_burst(-1, -1);
        chk("busy_release_latency", got_wait, 0);
        chk("busy_release_addr", got_addr, 15'd2);

        // cam_vsync during burst 5: that burst keeps 5, the next one restarts at 0.
        do_burst(-1, -1);
        do_burst(-1, -1);
        do_burst(200, -1);
        chk("vsync_burst_addr", got_addr, 15'd5);
        do_burst(-1, -1);
        chk("after_vsync_addr", got_addr, 15'd0);

        // Reset in the middle of write burst 1; indices restart.
        do_burst(-1, 100);
        chk("pre_reset_addr", got_addr, 15'd1);
        do_burst(-1, -1);
        chk("after_reset_addr", got_addr, 15'd0);
        wr_fifo_level = '0;
        repeat (4) @(posedge clk); #1;

        // Stray / underrun flags (sticky when built, always 0 otherwise).
        ctl_s2f_data_valid = 1'b1;
        @(posedge clk); #1;
        ctl_s2f_data_valid = 1'b0;
        @(negedge clk);
        chk("stray_set", err_stray, ERR_EN);
        chk("underrun_clear", err_underrun, 1'b0);
        repeat (5) @(posedge clk); #1;
        chk("stray_sticky", err_stray, ERR_EN);
        ctl_f2s_data_valid = 1'b1;
        @(posedge clk); #1;
        ctl_f2s_data_valid = 1'b0;
        @(negedge clk);
        chk("underrun_set", err_underrun, ERR_EN);
        rst_n = 1'b0;
        #1;
        chk("stray_reset", err_stray, 1'b0);
        chk("underrun_reset", err_underrun, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
